// File: rtl/pb_varint_stream_decoder_pkg.sv
// Shared types for the protobuf varint stream decoder: modes, error codes,
// wire types and the decoder state encoding.
package pb_varint_stream_decoder_pkg;

  localparam int unsigned MAX_VARINT_BYTES = 10;

  typedef enum logic [1:0] {
    PB_RAW    = 2'd0,
    PB_KEY    = 2'd1,
    PB_ZIGZAG = 2'd2
  } pb_mode_e;

  typedef enum logic [1:0] {
    PB_ERR_NONE      = 2'd0,
    PB_ERR_OVERLONG  = 2'd1,
    PB_ERR_TRUNCATED = 2'd2,
    PB_ERR_BAD_KEY   = 2'd3
  } pb_err_e;

  typedef enum logic [2:0] {
    PB_WT_VARINT = 3'd0,
    PB_WT_I64    = 3'd1,
    PB_WT_LEN    = 3'd2,
    PB_WT_SGROUP = 3'd3,
    PB_WT_EGROUP = 3'd4,
    PB_WT_I32    = 3'd5
  } pb_wire_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_OUT   = 2'd2,
    ST_DRAIN = 2'd3
  } pb_state_e;

endpackage

// File: rtl/pb_varint_stream_decoder_if.sv
// Byte-in / word-out handshake bundle of the varint decoder.
// slave = decoder side, master = byte source / result sink side.
interface pb_varint_stream_decoder_if
  import pb_varint_stream_decoder_pkg::*;
#(
  parameter int unsigned VALUE_W = 64,
  parameter int unsigned FIELD_W = 29
);
  pb_mode_e           cfg_mode;
  logic               s_valid;
  logic               s_ready;
  logic [7:0]         s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [VALUE_W-1:0] m_value;
  logic [FIELD_W-1:0] m_field_num;
  logic [2:0]         m_wire_type;
  logic [3:0]         m_len;
  pb_err_e            m_err;

  modport slave (
    input  cfg_mode, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_value, m_field_num, m_wire_type, m_len, m_err
  );

  modport master (
    output cfg_mode, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_value, m_field_num, m_wire_type, m_len, m_err
  );
endinterface

// File: rtl/pb_varint_stream_decoder.sv
// Streaming protobuf varint decoder: one byte per cycle in, one decoded word per varint out.
// Raw, key and zigzag modes; flags overlong, truncated and bad-key varints.
module pb_varint_stream_decoder
  import pb_varint_stream_decoder_pkg::*;
#(
  parameter int unsigned VALUE_W = 64,
  parameter int unsigned FIELD_W = 29
) (
  input logic                       clk,
  input logic                       rst_n,
  pb_varint_stream_decoder_if.slave bus
);
  localparam int unsigned MAX_BYTES = (VALUE_W == 64) ? MAX_VARINT_BYTES : (VALUE_W + 6) / 7;
  localparam logic [3:0]  LAST_IDX  = 4'(MAX_BYTES - 1);

  pb_state_e          r_state, w_state_nxt, w_base;
  logic [VALUE_W-1:0] r_acc;
  logic [3:0]         r_len;
  pb_mode_e           r_mode;
  logic               r_ovl, r_trunc, r_drain_armed;

  logic               w_out, w_s_fire, w_m_fire, w_cont, w_last;
  logic               w_start, w_acc_byte, w_drain_byte, w_ovl_hit;
  logic [VALUE_W-1:0] w_payload, w_value;
  logic [6:0]         w_shamt;
  logic [3:0]         w_len_inc;
  logic [FIELD_W-1:0] w_field;
  logic [2:0]         w_wt;
  logic               w_bad_key;
  pb_err_e            w_err;

  assign w_out     = (r_state == ST_OUT);
  assign w_cont    = bus.s_data[7];
  assign w_last    = bus.s_last;
  assign w_payload = VALUE_W'(bus.s_data[6:0]);
  assign w_shamt   = 7'(r_len) * 7'd7;
  assign w_len_inc = (r_len == 4'hF) ? r_len : r_len + 4'd1;
  assign w_s_fire  = bus.s_valid && (!w_out || bus.m_ready);
  assign w_m_fire  = w_out && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A byte accepted during the OUT handshake is handled as if the FSM had
  // already moved on (IDLE, or DRAIN after an overlong varint).
  always_comb begin
    w_base = r_state;
    if (w_out) w_base = r_drain_armed ? ST_DRAIN : ST_IDLE;
    w_start      = w_s_fire && (w_base == ST_IDLE);
    w_acc_byte   = w_s_fire && (w_base == ST_ACC);
    w_drain_byte = w_s_fire && (w_base == ST_DRAIN);
    w_ovl_hit    = w_acc_byte && w_cont && (r_len == LAST_IDX);

    w_state_nxt = r_state;
    if (w_m_fire) w_state_nxt = w_base;
    if (w_start)
      w_state_nxt = (w_cont && !w_last) ? ST_ACC : ST_OUT;
    else if (w_acc_byte)
      w_state_nxt = (w_cont && !w_last && (r_len != LAST_IDX)) ? ST_ACC : ST_OUT;
    else if (w_drain_byte)
      w_state_nxt = (w_cont && !w_last) ? ST_DRAIN : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_len         <= '0;
      r_mode        <= PB_RAW;
      r_ovl         <= 1'b0;
      r_trunc       <= 1'b0;
      r_drain_armed <= 1'b0;
    end else begin
      if (w_m_fire) r_drain_armed <= 1'b0;
      if (w_start) begin
        r_acc   <= w_payload;
        r_len   <= 4'd1;
        r_mode  <= bus.cfg_mode;
        r_ovl   <= 1'b0;
        r_trunc <= w_cont && w_last;
      end else if (w_acc_byte) begin
        r_acc         <= r_acc | (w_payload << w_shamt);
        r_len         <= w_len_inc;
        r_ovl         <= w_ovl_hit;
        r_trunc       <= w_cont && w_last;
        // a message boundary already ends the overlong run, so nothing to drain
        r_drain_armed <= w_ovl_hit && !w_last;
      end else if (w_drain_byte) begin
        r_len <= w_len_inc;
      end
    end
  end

  always_comb begin
    w_value   = r_acc;
    w_field   = '0;
    w_wt      = '0;
    w_bad_key = 1'b0;
    case (r_mode)
      PB_KEY: begin
        w_field   = r_acc[3 +: FIELD_W];
        w_wt      = r_acc[2:0];
        w_bad_key = (w_field == '0) || (w_wt > PB_WT_I32);
      end
      PB_ZIGZAG: w_value = (r_acc >> 1) ^ {VALUE_W{r_acc[0]}};
      default: ;
    endcase
    if (r_ovl)          w_err = PB_ERR_OVERLONG;
    else if (r_trunc)   w_err = PB_ERR_TRUNCATED;
    else if (w_bad_key) w_err = PB_ERR_BAD_KEY;
    else                w_err = PB_ERR_NONE;
  end

  assign bus.s_ready     = !w_out || bus.m_ready;
  assign bus.m_valid     = w_out;
  assign bus.m_value     = w_out ? w_value : '0;
  assign bus.m_field_num = w_out ? w_field : '0;
  assign bus.m_wire_type = w_out ? w_wt    : '0;
  assign bus.m_len       = w_out ? r_len   : '0;
  assign bus.m_err       = w_out ? w_err   : PB_ERR_NONE;

endmodule

// File: tb/tb_pb_varint_stream_decoder.sv
// Scoreboard bench for pb_varint_stream_decoder: directed cases plus a random
// back-to-back varint stream checked against a byte-list reference model.
module tb_pb_varint_stream_decoder;
  import pb_varint_stream_decoder_pkg::*;

  localparam int unsigned VW = 64;
  localparam int unsigned FW = 29;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pb_varint_stream_decoder_if #(.VALUE_W(VW), .FIELD_W(FW)) bus();
  pb_varint_stream_decoder #(.VALUE_W(VW), .FIELD_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] value;
    logic [28:0] field;
    logic [2:0]  wt;
    logic [3:0]  len;
    pb_err_e     err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned term_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int          rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled
  bit          gaps = 1'b0;
  bit          mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic exp_t mk(input logic [63:0] v, input logic [28:0] f, input logic [2:0] wt,
                              input logic [3:0] len, input pb_err_e err);
    exp_t e;
    e.value = v; e.field = f; e.wt = wt; e.len = len; e.err = err;
    return e;
  endfunction

  // Reference: decode one varint record (all bytes including any drained tail).
  function automatic exp_t model(input logic [7:0] b[$], input pb_mode_e mode, input bit last);
    logic [63:0] acc = '0;
    int unsigned n = b.size();
    int unsigned used = (n < 10) ? n : 10;
    exp_t e;
    for (int unsigned i = 0; i < used; i++) acc = acc | (64'(b[i] & 8'h7f) << (7 * i));
    e = mk(acc, '0, '0, 4'(used), PB_ERR_NONE);
    if (mode == PB_ZIGZAG) e.value = acc[0] ? (64'd0 - (acc >> 1) - 64'd1) : (acc >> 1);
    if (mode == PB_KEY) begin
      e.field = 29'(acc >> 3);
      e.wt    = 3'(acc % 8);
    end
    if (used == 10 && b[9][7])                                   e.err = PB_ERR_OVERLONG;
    else if (b[n-1][7] && last)                                  e.err = PB_ERR_TRUNCATED;
    else if (mode == PB_KEY && (e.field == 0 || e.wt > 3'd5))    e.err = PB_ERR_BAD_KEY;
    return e;
  endfunction

  task automatic wait_accept(input bit mark);
    bit done = 1'b0;
    for (int unsigned k = 0; k < 500 && !done; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        if (mark) term_q.push_back(cyc + 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 1'b0, "s_ready never seen within 500 cycles");
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit last, input pb_mode_e mode, input bit mark);
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_last   = last;
    bus.cfg_mode = mode;
    wait_accept(mark);
  endtask

  task automatic send_rec(input logic [7:0] b[$], input pb_mode_e mode, input bit last, input exp_t e);
    int unsigned used = (b.size() < 10) ? b.size() : 10;
    exp_q.push_back(e);
    for (int unsigned i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive_byte(b[i], last && (i == b.size() - 1),
                 (i == 0) ? mode : pb_mode_e'($urandom_range(0, 2)), i == used - 1);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_empty();
    for (int unsigned k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_queue", exp_q.size() == 0, $sformatf("%0d results outstanding, required 0", exp_q.size()));
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready = ($urandom_range(0, 3) != 0);
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on each new result, stability while stalled, scoreboard on handshake.
  initial begin
    bit   prev_busy = 1'b0;
    exp_t held, cur, e;
    int unsigned t;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && bus.m_valid) begin
        cur = mk(bus.m_value, bus.m_field_num, bus.m_wire_type, bus.m_len, bus.m_err);
        if (!prev_busy) begin
          if (term_q.size() == 0) check("latency", 1'b0, "result with no terminating byte accepted");
          else begin
            t = term_q.pop_front();
            check("latency", cyc == t, $sformatf("m_valid at cycle %0d, required %0d", cyc, t));
          end
        end else begin
          check("hold_stable", cur == held, $sformatf("outputs %h, required held %h", cur, held));
        end
        held = cur;
        if (!bus.m_ready)
          check("s_ready_stall", bus.s_ready == 1'b0, $sformatf("s_ready=%0b, required 0", bus.s_ready));
        if (bus.m_ready) begin
          if (exp_q.size() == 0) check("result", 1'b0, $sformatf("unexpected result %h", cur));
          else begin
            e = exp_q.pop_front();
            check("result", cur == e,
                  $sformatf("got v=%h f=%0d wt=%0d len=%0d err=%0d, required v=%h f=%0d wt=%0d len=%0d err=%0d",
                            cur.value, cur.field, cur.wt, cur.len, cur.err,
                            e.value, e.field, e.wt, e.len, e.err));
          end
        end
        prev_busy = !bus.m_ready;
      end else begin
        prev_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int unsigned n;
    bit last;
    pb_mode_e mode;

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.cfg_mode = PB_RAW; bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          bus.m_valid == 0 && bus.s_ready == 1 && bus.m_value == 0 && bus.m_field_num == 0 &&
          bus.m_wire_type == 0 && bus.m_len == 0 && bus.m_err == PB_ERR_NONE,
          $sformatf("m_valid=%0b s_ready=%0b m_value=%h len=%0d err=%0d, required 0 1 0 0 0",
                    bus.m_valid, bus.s_ready, bus.m_value, bus.m_len, bus.m_err));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed
    q = '{8'h96, 8'h01}; send_rec(q, PB_RAW, 1'b0, mk(64'd150, 0, 0, 4'd2, PB_ERR_NONE));
    q = '{8'h08};        send_rec(q, PB_KEY, 1'b0, mk(64'd8, 29'd1, 3'd0, 4'd1, PB_ERR_NONE));
    q = '{8'h1A};        send_rec(q, PB_KEY, 1'b0, mk(64'd26, 29'd3, 3'd2, 4'd1, PB_ERR_NONE));
    q = '{8'h07};        send_rec(q, PB_KEY, 1'b0, mk(64'd7, 29'd0, 3'd7, 4'd1, PB_ERR_BAD_KEY));
    q = '{8'h03};        send_rec(q, PB_ZIGZAG, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 4'd1, PB_ERR_NONE));
    q = '{8'h04};        send_rec(q, PB_ZIGZAG, 1'b0, mk(64'd2, 0, 0, 4'd1, PB_ERR_NONE));
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'hFF);
    q.push_back(8'h01);
    send_rec(q, PB_ZIGZAG, 1'b0, mk(64'h8000_0000_0000_0000, 0, 0, 4'd10, PB_ERR_NONE));
    q = {};
    for (int i = 0; i < 11; i++) q.push_back(8'hFF);
    q.push_back(8'h00);
    send_rec(q, PB_RAW, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 4'd10, PB_ERR_OVERLONG));
    q = '{8'h05};        send_rec(q, PB_RAW, 1'b0, mk(64'd5, 0, 0, 4'd1, PB_ERR_NONE));
    wait_empty();

    // truncated result held under a 5-cycle stall
    rdy_mode = 2;
    @(posedge clk); #1;
    q = '{8'h80};        send_rec(q, PB_RAW, 1'b1, mk(64'd0, 0, 0, 4'd1, PB_ERR_TRUNCATED));
    repeat (5) @(posedge clk);
    rdy_mode = 1;
    wait_empty();

    // asynchronous reset aborts a held result and a partial varint
    mon_en = 1'b0; rdy_mode = 2;
    @(posedge clk); #1;
    drive_byte(8'h2A, 1'b0, PB_RAW, 1'b0);
    bus.s_valid = 1'b0;
    check("pre_reset_result", bus.m_valid == 1 && bus.m_value == 64'd42,
          $sformatf("m_valid=%0b m_value=%0d, required 1 42", bus.m_valid, bus.m_value));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset",
          bus.m_valid == 0 && bus.s_ready == 1 && bus.m_value == 0 && bus.m_len == 0 && bus.m_err == PB_ERR_NONE,
          $sformatf("m_valid=%0b s_ready=%0b m_value=%h len=%0d, required 0 1 0 0",
                    bus.m_valid, bus.s_ready, bus.m_value, bus.m_len));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_byte(8'hAC, 1'b0, PB_RAW, 1'b0);
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_partial", bus.m_valid == 0 && bus.s_ready == 1,
          $sformatf("m_valid=%0b s_ready=%0b, required 0 1", bus.m_valid, bus.s_ready));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 1; mon_en = 1'b1;
    q = '{8'h01};        send_rec(q, PB_RAW, 1'b0, mk(64'd1, 0, 0, 4'd1, PB_ERR_NONE));
    wait_empty();

    // random back-to-back stream with gaps and backpressure
    rdy_mode = 0; gaps = 1'b1;
    for (int r = 0; r < 300; r++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 13) : $urandom_range(1, 3);
      mode = pb_mode_e'($urandom_range(0, 2));
      q = {};
      last = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (i < n - 1) b[7] = 1'b1;
        else if ($urandom_range(0, 3) == 0) begin b[7] = 1'b1; last = 1'b1; end
        else begin b[7] = 1'b0; last = 1'($urandom_range(0, 1)); end
        q.push_back(b);
      end
      send_rec(q, mode, last, model(q, mode, last));
    end
    rdy_mode = 1;
    wait_empty();
    check("latency_queue", term_q.size() == 0,
          $sformatf("%0d unmatched terminating bytes, required 0", term_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
